full_adder_using_ha: RTL and testbench

//  Full adder built structurally from half-adder cells: per bit, two half adders plus an OR
//  for carry-out. Generalises to a WIDTH-bit ripple-carry adder with carry-in.

---
 rtl/full_adder_using_ha.sv | 78 +++++++
 tb/tb_full_adder_using_ha.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/full_adder_using_ha.sv
// Ripple-carry adder built from half-adder cells, with an optional output register.
// Each bit uses two half adders and an OR; the chain carries from bit 0 upward.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic co
);
    assign s  = x ^ y;
    assign co = x & y;
endmodule

module full_adder_using_ha #(
    parameter int unsigned WIDTH   = 1,
    parameter bit          REG_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    // carry_chain[i] is the carry into bit i; carry_chain[WIDTH] is the final carry-out
    logic [WIDTH:0]   carry_chain;
    logic [WIDTH-1:0] sum_comb;

    assign carry_chain[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic s1;
        logic c1;
        logic c2;

        half_adder u_ha1 (
            .x  (a[i]),
            .y  (b[i]),
            .s  (s1),
            .co (c1)
        );

        half_adder u_ha2 (
            .x  (s1),
            .y  (carry_chain[i]),
            .s  (sum_comb[i]),
            .co (c2)
        );

        assign carry_chain[i+1] = c1 | c2;
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic             carry_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else begin
                sum_q   <= sum_comb;
                carry_q <= carry_chain[WIDTH];
            end
        end

        assign sum   = sum_q;
        assign carry = carry_q;
    end else begin : g_comb
        // clk and rst_n are intentionally unused in the purely combinational build
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign sum   = sum_comb;
        assign carry = carry_chain[WIDTH];
    end
endmodule

// File: tb/tb_full_adder_using_ha.sv
// Bench for full_adder_using_ha: combinational and registered builds at several widths,
// checked against an arithmetic model plus literal expectations for the directed cases.

module tb_full_adder_using_ha;
    logic clk;
    logic rst_n;

    logic [0:0] a1, b1;  logic c1;  logic [0:0] s1;  logic co1;
    logic [3:0] a4, b4;  logic c4;  logic [3:0] s4;  logic co4;
    logic [0:0] ar, br;  logic cr;  logic [0:0] sr;  logic cor;
    logic [7:0] a8, b8;  logic c8;  logic [7:0] s8c; logic co8c;
    logic [7:0] s8r;     logic co8r;

    logic [1:0] exp_r1;
    logic [8:0] exp_r8;

    int checks;
    int errors;

    full_adder_using_ha #(.WIDTH(1), .REG_OUT(1'b0)) u_w1c (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .sum(s1), .carry(co1));
    full_adder_using_ha #(.WIDTH(4), .REG_OUT(1'b0)) u_w4c (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c(c4), .sum(s4), .carry(co4));
    full_adder_using_ha #(.WIDTH(1), .REG_OUT(1'b1)) u_w1r (
        .clk(clk), .rst_n(rst_n), .a(ar), .b(br), .c(cr), .sum(sr), .carry(cor));
    full_adder_using_ha #(.WIDTH(8), .REG_OUT(1'b0)) u_w8c (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8), .sum(s8c), .carry(co8c));
    full_adder_using_ha #(.WIDTH(8), .REG_OUT(1'b1)) u_w8r (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8), .sum(s8r), .carry(co8r));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Registered model: whole-number sum of what was on the inputs at the edge, cleared by reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_r1 <= '0;
            exp_r8 <= '0;
        end else begin
            exp_r1 <= 2'(ar) + 2'(br) + 2'(cr);
            exp_r8 <= 9'(a8) + 9'(b8) + 9'(c8);
        end
    end

    always begin
        @(posedge clk);
        #2;
        check("w1c_model", {7'd0, co1, s1},  9'(a1) + 9'(b1) + 9'(c1));
        check("w4c_model", {4'd0, co4, s4},  9'(a4) + 9'(b4) + 9'(c4));
        check("w8c_model", {co8c, s8c},      9'(a8) + 9'(b8) + 9'(c8));
        check("w1r_model", {7'd0, cor, sr},  {7'd0, exp_r1});
        check("w8r_model", {co8r, s8r},      exp_r8);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] t1_exp [8];
        logic [3:0] pat;
        t1_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        checks = 0;
        errors = 0;

        rst_n = 1'b0;
        a1 = '0; b1 = '0; c1 = 1'b0;
        a4 = '0; b4 = '0; c4 = 1'b0;
        ar = '0; br = '0; cr = 1'b0;
        a8 = '0; b8 = '0; c8 = 1'b0;

        #1;
        check("reset_w1r", {7'd0, cor, sr}, 9'd0);
        check("reset_w8r", {co8r, s8r}, 9'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1-bit truth table sweep, {a,b,c} = 000..111
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pat = 4'(i);
            a1 = pat[2]; b1 = pat[1]; c1 = pat[0];
            #1;
            check($sformatf("tt_%0d", i), {7'd0, co1, s1}, {7'd0, t1_exp[i]});
        end

        // 4-bit corners and the full ripple path
        @(negedge clk); a4 = 4'hF; b4 = 4'h1; c4 = 1'b0; #1;
        check("w4_f_plus_1", {4'd0, co4, s4}, 9'h010);
        @(negedge clk); a4 = 4'hF; b4 = 4'hF; c4 = 1'b1; #1;
        check("w4_f_f_1", {4'd0, co4, s4}, 9'h01F);
        @(negedge clk); a4 = 4'h5; b4 = 4'hA; c4 = 1'b0; #1;
        check("w4_5_a_0", {4'd0, co4, s4}, 9'h00F);
        c4 = 1'b1; #1;
        check("w4_5_a_ripple", {4'd0, co4, s4}, 9'h010);

        // Registered: result appears only after the capturing edge
        @(negedge clk); ar = 1'b1; br = 1'b1; cr = 1'b1; #1;
        check("reg_before_edge", {7'd0, cor, sr}, 9'd0);
        @(posedge clk); #1;
        check("reg_after_edge", {7'd0, cor, sr}, 9'd3);

        // Asynchronous reset between edges, held through an edge, released between edges
        #2; rst_n = 1'b0; #1;
        check("rst_immediate", {7'd0, cor, sr}, 9'd0);
        @(posedge clk); #1;
        check("rst_held_edge", {7'd0, cor, sr}, 9'd0);
        @(negedge clk); #1; rst_n = 1'b1; #1;
        check("rst_released_no_edge", {7'd0, cor, sr}, 9'd0);
        @(posedge clk); #1;
        check("rst_first_capture", {7'd0, cor, sr}, 9'd3);

        // 8-bit directed boundaries
        @(negedge clk); a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; #1;
        check("w8_max", {co8c, s8c}, 9'h1FF);
        @(negedge clk); a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; #1;
        check("w8_ripple", {co8c, s8c}, 9'h100);
        @(negedge clk); a8 = 8'h80; b8 = 8'h80; c8 = 1'b0; #1;
        check("w8_msb_carry", {co8c, s8c}, 9'h100);
        @(posedge clk); #1;
        check("w8r_msb_carry", {co8r, s8r}, 9'h100);

        // Random 8-bit vectors; the per-cycle compare checks both builds against the model
        for (int n = 0; n < 1200; n++) begin
            @(negedge clk);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            c8 = 1'($urandom);
            ar = 1'($urandom);
            br = 1'($urandom);
            cr = 1'($urandom);
            a1 = 1'($urandom);
            b1 = 1'($urandom);
            c1 = 1'($urandom);
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            c4 = 1'($urandom);
        end

        @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
